// File: rtl/weapons_array.sv
// Multi-channel weapon controller: each channel runs a READY/COOL/RELOAD FSM
// with its own ammo store; a shared capacity register bounds every channel.
module weapons_ch #(
  parameter int AW  = 9,
  parameter int CW  = 4,
  parameter int RLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fire_i,
  input  logic          load_i,
  input  logic          attack_i,
  input  logic [AW-1:0] load_val_i,
  input  logic [CW-1:0] cooldown_i,
  input  logic [AW-1:0] cap_i,
  output logic [AW-1:0] ammo_o,
  output logic          ready_o,
  output logic          shot_o,
  output logic          err_o
);
  typedef enum logic [1:0] {READY, COOL, RELOAD} st_t;

  st_t           state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [AW-1:0] ammo_q, ammo_d;
  logic [AW-1:0] amt_q, amt_d;
  logic          shot_q, shot_d;
  logic          err_q, err_d;
  logic          clamp, reload_done;
  logic [AW:0]   sum;
  logic [AW-1:0] refill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= READY;
      timer_q <= '0;
      ammo_q  <= '0;
      amt_q   <= '0;
      shot_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ammo_q  <= ammo_d;
      amt_q   <= amt_d;
      shot_q  <= shot_d;
      err_q   <= err_d;
    end
  end

  // Refill is summed one bit wider so it saturates at cap instead of wrapping.
  assign sum         = {1'b0, ammo_q} + {1'b0, amt_q};
  assign refill      = (sum > {1'b0, cap_i}) ? cap_i : sum[AW-1:0];
  assign clamp       = ammo_q > cap_i;
  assign reload_done = (state_q == RELOAD) && (timer_q <= CW'(1));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ammo_d  = ammo_q;
    amt_d   = amt_q;
    shot_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      READY: begin
        if (load_i) begin
          amt_d   = load_val_i;
          timer_d = CW'(RLD);
          state_d = RELOAD;
        end else if (fire_i) begin
          if (attack_i && ammo_q != '0) begin
            if (!clamp) begin
              shot_d = 1'b1;
              ammo_d = ammo_q - 1'b1;
              // A cooldown of 0 or 1 still allows a shot every cycle.
              if (cooldown_i > CW'(1)) begin
                state_d = COOL;
                timer_d = cooldown_i;
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COOL: begin
        if (load_i) begin
          amt_d   = load_val_i;
          timer_d = CW'(RLD);
          state_d = RELOAD;
        end else begin
          // Back to READY as the timer reaches 1, giving a spacing of exactly cooldown.
          timer_d = timer_q - 1'b1;
          if (timer_q <= CW'(2)) state_d = READY;
        end
      end
      RELOAD: begin
        err_d = fire_i;
        if (reload_done) begin
          ammo_d  = refill;
          timer_d = '0;
          state_d = READY;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = READY;
    endcase
    if (clamp && !reload_done) ammo_d = cap_i;
  end

  always_comb begin
    ready_o = (state_q == READY) && (ammo_q != '0);
    shot_o  = shot_q;
    err_o   = err_q;
    ammo_o  = ammo_q;
  end
endmodule

module weapons_array #(
  parameter int NCH     = 4,
  parameter int AW      = 9,
  parameter int CW      = 4,
  parameter int RLD     = 8,
  parameter int CAP_RST = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mode,
  input  logic [NCH-1:0]    fire,
  input  logic [NCH-1:0]    load,
  input  logic [AW-1:0]     load_val,
  input  logic [CW-1:0]     cooldown,
  input  logic              cap_we,
  input  logic [AW-1:0]     cap_val,
  output logic [NCH*AW-1:0] ammo,
  output logic [NCH-1:0]    ready,
  output logic [NCH-1:0]    shot,
  output logic [NCH-1:0]    err
);
  logic [AW-1:0] cap_q;
  logic          attack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cap_q <= AW'(CAP_RST);
    else if (cap_we) cap_q <= cap_val;
  end

  assign attack = (mode == 4'b0010);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    weapons_ch #(.AW(AW), .CW(CW), .RLD(RLD)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .fire_i     (fire[g]),
      .load_i     (load[g]),
      .attack_i   (attack),
      .load_val_i (load_val),
      .cooldown_i (cooldown),
      .cap_i      (cap_q),
      .ammo_o     (ammo[g*AW +: AW]),
      .ready_o    (ready[g]),
      .shot_o     (shot[g]),
      .err_o      (err[g])
    );
  end
endmodule
